// File: rtl/ahb_pkg.sv
// Shared AHB encodings, arbiter state type and burst-length helper.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_BURST = 2'd2,
    ST_INCR  = 2'd3
  } arb_state_t;

  // Beats minus one for fixed-length bursts; SINGLE and INCR return 0.
  function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
    logic [3:0] beats;
    case (hburst)
      HBURST_WRAP4, HBURST_INCR4:   beats = 4'd3;
      HBURST_WRAP8, HBURST_INCR8:   beats = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: beats = 4'd15;
      default:                      beats = 4'd0;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, cyclic.
module ahb_rr_pick #(
  parameter int N  = 5,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [PW-1:0] o_idx,
  output logic          o_valid
);

  // Scan N positions starting at the pointer; the first hit wins.
  always_comb begin
    int j;
    j        = 0;
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(i_ptr) + k;
      if (j >= N) j = j - N;
      if (!o_valid && i_req[j]) begin
        o_valid     = 1'b1;
        o_onehot[j] = 1'b1;
        o_idx       = PW'(j);
      end
    end
  end

endmodule

// File: rtl/ahb_slv_arbiter.sv
// Round-robin arbiter for one AHB slave port. Holds ownership for a whole
// transfer or burst, hands over only on hready_s, and tracks the data-phase
// owner so write data and responses reach the right master.
//
// Handshake: a beat of the address owner is accepted on a rising edge where
// hready_s=1; with hready_s=0 every register holds its value.
module ahb_slv_arbiter
  import ahb_pkg::*;
#(
  parameter int HMAS_NUM     = 5,
  parameter int HBURST_WIDTH = 3,
  localparam int PW          = $clog2(HMAS_NUM)
) (
  input  logic                           hclk,
  input  logic                           hrst,
  input  logic [HMAS_NUM-1:0]            req_m,
  input  logic [2*HMAS_NUM-1:0]          htrans_m,
  input  logic [HBURST_WIDTH*HMAS_NUM-1:0] hburst_m,
  input  logic                           hready_s,
  output logic [HMAS_NUM-1:0]            grant,
  output logic [PW-1:0]                  grant_idx,
  output logic [HMAS_NUM-1:0]            dgrant,
  output logic                           hsel_s,
  output logic [HMAS_NUM-1:0]            hready_m,
  output arb_state_t                     o_dbg_state
);

  arb_state_t          r_state, w_state_nxt, w_ns_state;
  logic [HMAS_NUM-1:0] r_grant, w_grant_nxt;
  logic [PW-1:0]       r_grant_idx, w_grant_idx_nxt;
  logic [HMAS_NUM-1:0] r_dgrant, w_dgrant_nxt;
  logic [PW-1:0]       r_ptr, w_ptr_nxt;
  // Counter holds the SEQ beats still to come; the SEQ that takes it to 0
  // is the last beat of the burst.
  logic [3:0]          r_cnt, w_cnt_nxt;

  logic [1:0]              w_own_htrans;
  logic [HBURST_WIDTH-1:0] w_own_hburst;
  logic                    w_owned, w_own_req, w_own_ns, w_own_seq, w_own_idle;
  logic                    w_own_single, w_arb;
  logic [3:0]              w_own_beats;
  logic [HMAS_NUM-1:0]     w_pick_onehot;
  logic [PW-1:0]           w_pick_idx;
  logic                    w_pick_valid;

  ahb_rr_pick #(.N(HMAS_NUM), .PW(PW)) u_pick (
    .i_req    (req_m),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  assign w_own_htrans = htrans_m[2*int'(r_grant_idx) +: 2];
  assign w_own_hburst = hburst_m[HBURST_WIDTH*int'(r_grant_idx) +: HBURST_WIDTH];
  assign w_owned      = |r_grant;
  assign w_own_req    = |(req_m & r_grant);
  assign w_own_ns     = w_owned && (w_own_htrans == HTRANS_NONSEQ);
  assign w_own_seq    = w_owned && (w_own_htrans == HTRANS_SEQ);
  assign w_own_idle   = w_owned && (w_own_htrans == HTRANS_IDLE);
  assign w_own_single = (w_own_hburst[2:0] == HBURST_SINGLE);
  assign w_own_beats  = burst_beats(w_own_hburst[2:0]);
  assign w_ns_state   = (w_own_hburst[2:0] == HBURST_INCR)   ? ST_INCR :
                        (w_own_hburst[2:0] == HBURST_SINGLE) ? ST_OWN  : ST_BURST;

  // Arbitration point: the owner's transfer/burst is done or abandoned.
  always_comb begin
    w_arb = 1'b0;
    case (r_state)
      ST_IDLE:  w_arb = 1'b1;
      ST_OWN:   w_arb = w_own_idle || (w_own_ns && w_own_single);
      ST_BURST: w_arb = w_own_idle || (w_own_ns && w_own_single) ||
                        (w_own_seq && (r_cnt == 4'd1));
      ST_INCR:  w_arb = w_own_idle || w_own_ns;
      default:  w_arb = 1'b0;
    endcase
    if (r_state != ST_IDLE && !w_own_req) w_arb = 1'b1;
    w_arb = w_arb && hready_s;
  end

  // Next-state, grant, pointer, counter and data-owner update.
  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_grant_idx_nxt = r_grant_idx;
    w_dgrant_nxt    = r_dgrant;
    w_ptr_nxt       = r_ptr;
    w_cnt_nxt       = r_cnt;
    if (hready_s) begin
      w_dgrant_nxt = (w_own_ns || w_own_seq) ? r_grant : '0;
      if (w_arb) begin
        if (w_pick_valid) begin
          w_grant_nxt     = w_pick_onehot;
          w_grant_idx_nxt = w_pick_idx;
          w_ptr_nxt       = (w_pick_idx == PW'(HMAS_NUM-1)) ? '0 : w_pick_idx + 1'b1;
          // A lone owner re-winning with a fresh NONSEQ starts that transfer.
          if ((w_pick_onehot == r_grant) && w_own_ns) begin
            w_state_nxt = w_ns_state;
            w_cnt_nxt   = w_own_beats;
          end else begin
            w_state_nxt = ST_OWN;
            w_cnt_nxt   = 4'd0;
          end
        end else begin
          w_grant_nxt     = '0;
          w_grant_idx_nxt = '0;
          w_state_nxt     = ST_IDLE;
          w_cnt_nxt       = 4'd0;
        end
      end else if (w_own_ns) begin
        w_state_nxt = w_ns_state;
        w_cnt_nxt   = w_own_beats;
      end else if (w_own_seq && (r_state == ST_BURST)) begin
        w_cnt_nxt = r_cnt - 4'd1;
      end
    end
  end

  // State registers; reset wins over everything, including an open burst.
  always_ff @(posedge hclk) begin
    if (hrst) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_grant_idx <= '0;
      r_dgrant    <= '0;
      r_ptr       <= '0;
      r_cnt       <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_grant_idx <= w_grant_idx_nxt;
      r_dgrant    <= w_dgrant_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  // Per-master hready: owners follow the slave, other requesters stall.
  // While reset is held no master is stalled.
  always_comb begin
    hready_m = '1;
    for (int i = 0; i < HMAS_NUM; i++) begin
      if (hrst)                         hready_m[i] = 1'b1;
      else if (r_grant[i] || r_dgrant[i]) hready_m[i] = hready_s;
      else if (req_m[i])                hready_m[i] = 1'b0;
    end
  end

  assign grant       = r_grant;
  assign grant_idx   = r_grant_idx;
  assign dgrant      = r_dgrant;
  assign hsel_s      = |r_grant;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ahb_slv_arbiter.sv
// Directed bench for ahb_slv_arbiter: each step drives one cycle of inputs and
// queues the outputs expected during that cycle; a monitor pops and compares.
module tb_ahb_slv_arbiter;
  import ahb_pkg::*;

  localparam int N = 5;

  logic             hclk = 1'b0;
  logic             hrst = 1'b1;
  logic [N-1:0]     req_m = '0;
  logic [2*N-1:0]   htrans_m = '0;
  logic [3*N-1:0]   hburst_m = '0;
  logic             hready_s = 1'b1;
  logic [N-1:0]     grant, dgrant, hready_m;
  logic [2:0]       grant_idx;
  logic             hsel_s;
  arb_state_t       dbg_state;

  // Clock and reset
  always #5 hclk = ~hclk;

  ahb_slv_arbiter #(.HMAS_NUM(N), .HBURST_WIDTH(3)) dut (
    .hclk        (hclk),
    .hrst        (hrst),
    .req_m       (req_m),
    .htrans_m    (htrans_m),
    .hburst_m    (hburst_m),
    .hready_s    (hready_s),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .dgrant      (dgrant),
    .hsel_s      (hsel_s),
    .hready_m    (hready_m),
    .o_dbg_state (dbg_state)
  );

  localparam logic [1:0] NS = HTRANS_NONSEQ;
  localparam logic [1:0] SQ = HTRANS_SEQ;
  localparam logic [2*N-1:0] ALL_NS = 10'b10_10_10_10_10;

  // Expected entry: {step, state, hready_m, dgrant, grant}
  logic [24:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int steps  = 0;

  function automatic logic [2*N-1:0] tr(input int m, input logic [1:0] t);
    logic [2*N-1:0] v;
    v = '0;
    v[2*m +: 2] = t;
    return v;
  endfunction

  function automatic logic [3*N-1:0] bu(input int m, input logic [2:0] b);
    logic [3*N-1:0] v;
    v = '0;
    v[3*m +: 3] = b;
    return v;
  endfunction

  function automatic logic [2:0] idx_of(input logic [N-1:0] g);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (g[i]) r = 3'(i);
    return r;
  endfunction

  // Driver: apply one cycle of inputs and queue the outputs expected during it.
  task automatic step(input logic rst, input logic [N-1:0] req,
                      input logic [2*N-1:0] ht, input logic [3*N-1:0] hb,
                      input logic rdy, input logic [N-1:0] eg,
                      input logic [N-1:0] ed, input logic [N-1:0] eh,
                      input arb_state_t es);
    @(posedge hclk);
    #1;
    hrst     = rst;
    req_m    = req;
    htrans_m = ht;
    hburst_m = hb;
    hready_s = rdy;
    exp_q.push_back({steps[7:0], es, eh, ed, eg});
    steps++;
  endtask

  task automatic check(input string nm, input int tag,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, tag, act, exp);
    end
  endtask

  // Scoreboard monitor: compares mid-cycle, away from the active edge.
  always @(negedge hclk) begin
    logic [24:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("grant",     int'(e[24:17]), 32'(grant),     32'(e[4:0]));
      check("dgrant",    int'(e[24:17]), 32'(dgrant),    32'(e[9:5]));
      check("hready_m",  int'(e[24:17]), 32'(hready_m),  32'(e[14:10]));
      check("state",     int'(e[24:17]), 32'(dbg_state), 32'(e[16:15]));
      check("grant_idx", int'(e[24:17]), 32'(grant_idx), 32'(idx_of(e[4:0])));
      check("hsel_s",    int'(e[24:17]), 32'(hsel_s),    32'(|e[4:0]));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with every master requesting
    repeat (3) step(1, 5'b11111, ALL_NS, '0, 1, 5'b00000, 5'b00000, 5'b11111, ST_IDLE);
    // Round robin over SINGLE NONSEQ beats
    step(0, 5'b11111, ALL_NS, '0, 1, 5'b00000, 5'b00000, 5'b00000, ST_IDLE);
    step(0, 5'b11111, ALL_NS, '0, 1, 5'b00001, 5'b00000, 5'b00001, ST_OWN);
    step(0, 5'b11111, ALL_NS, '0, 1, 5'b00010, 5'b00001, 5'b00011, ST_OWN);
    step(0, 5'b11111, ALL_NS, '0, 1, 5'b00100, 5'b00010, 5'b00110, ST_OWN);
    step(0, 5'b11111, ALL_NS, '0, 1, 5'b01000, 5'b00100, 5'b01100, ST_OWN);
    step(0, 5'b11111, ALL_NS, '0, 1, 5'b10000, 5'b01000, 5'b11000, ST_OWN);
    step(1, 5'b11111, ALL_NS, '0, 1, 5'b00001, 5'b10000, 5'b11111, ST_OWN);

    // INCR4 by master 2 while master 0 waits; same-edge regrant at the end
    step(0, 5'b00100, tr(2, NS), bu(2, HBURST_INCR4), 1, 5'b00000, 5'b00000, 5'b11011, ST_IDLE);
    step(0, 5'b00101, tr(2, NS) | tr(0, NS), bu(2, HBURST_INCR4), 1, 5'b00100, 5'b00000, 5'b11110, ST_OWN);
    repeat (3) step(0, 5'b00101, tr(2, SQ) | tr(0, NS), bu(2, HBURST_INCR4), 1, 5'b00100, 5'b00100, 5'b11110, ST_BURST);
    step(0, 5'b00001, tr(0, NS), '0, 1, 5'b00001, 5'b00100, 5'b11111, ST_OWN);
    step(1, 5'b00001, tr(0, NS), '0, 1, 5'b00001, 5'b00001, 5'b11111, ST_OWN);

    // INCR8 by master 4 with wait states on beats 3 and 6; master 1 waits
    step(0, 5'b10000, tr(4, NS), bu(4, HBURST_INCR8), 1, 5'b00000, 5'b00000, 5'b01111, ST_IDLE);
    step(0, 5'b10010, tr(4, NS) | tr(1, NS), bu(4, HBURST_INCR8), 1, 5'b10000, 5'b00000, 5'b11101, ST_OWN);
    step(0, 5'b10010, tr(4, SQ) | tr(1, NS), bu(4, HBURST_INCR8), 1, 5'b10000, 5'b10000, 5'b11101, ST_BURST);
    step(0, 5'b10010, tr(4, SQ) | tr(1, NS), bu(4, HBURST_INCR8), 0, 5'b10000, 5'b10000, 5'b01101, ST_BURST);
    repeat (3) step(0, 5'b10010, tr(4, SQ) | tr(1, NS), bu(4, HBURST_INCR8), 1, 5'b10000, 5'b10000, 5'b11101, ST_BURST);
    step(0, 5'b10010, tr(4, SQ) | tr(1, NS), bu(4, HBURST_INCR8), 0, 5'b10000, 5'b10000, 5'b01101, ST_BURST);
    repeat (3) step(0, 5'b10010, tr(4, SQ) | tr(1, NS), bu(4, HBURST_INCR8), 1, 5'b10000, 5'b10000, 5'b11101, ST_BURST);
    step(0, 5'b00010, '0, '0, 1, 5'b00010, 5'b10000, 5'b11111, ST_OWN);
    step(1, 5'b00010, '0, '0, 1, 5'b00010, 5'b00000, 5'b11111, ST_OWN);

    // INCR by master 1 ends with IDLE after 5 beats; master 3 takes over
    step(0, 5'b00010, tr(1, NS), bu(1, HBURST_INCR), 1, 5'b00000, 5'b00000, 5'b11101, ST_IDLE);
    step(0, 5'b01010, tr(1, NS) | tr(3, NS), bu(1, HBURST_INCR), 1, 5'b00010, 5'b00000, 5'b10111, ST_OWN);
    repeat (4) step(0, 5'b01010, tr(1, SQ) | tr(3, NS), bu(1, HBURST_INCR), 1, 5'b00010, 5'b00010, 5'b10111, ST_INCR);
    step(0, 5'b01010, tr(3, NS), '0, 1, 5'b00010, 5'b00010, 5'b10111, ST_INCR);
    step(0, 5'b01000, tr(3, NS), '0, 1, 5'b01000, 5'b00000, 5'b11111, ST_OWN);
    step(1, 5'b01000, tr(3, NS), '0, 1, 5'b01000, 5'b01000, 5'b11111, ST_OWN);

    // Reset during beat 2 of WRAP16; pointer must restart at 0
    step(0, 5'b01000, tr(3, NS), bu(3, HBURST_WRAP16), 1, 5'b00000, 5'b00000, 5'b10111, ST_IDLE);
    step(0, 5'b01000, tr(3, NS), bu(3, HBURST_WRAP16), 1, 5'b01000, 5'b00000, 5'b11111, ST_OWN);
    step(1, 5'b01000, tr(3, SQ), bu(3, HBURST_WRAP16), 1, 5'b01000, 5'b01000, 5'b11111, ST_BURST);
    step(0, 5'b11010, tr(1, NS) | tr(3, NS) | tr(4, NS), '0, 1, 5'b00000, 5'b00000, 5'b00101, ST_IDLE);
    step(0, 5'b11010, tr(1, NS) | tr(3, NS) | tr(4, NS), '0, 1, 5'b00010, 5'b00000, 5'b00111, ST_OWN);
    step(0, 5'b11010, tr(1, NS) | tr(3, NS) | tr(4, NS), '0, 1, 5'b01000, 5'b00010, 5'b01111, ST_OWN);

    // Drain the scoreboard within a bounded number of cycles
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge hclk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end
    @(posedge hclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
